// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//
// Purpose:
//   Definitions shared between the router and the route programmer:
//   default channel geometry, default update strobe width and the
//   programmer's state encoding.
//
// Contents:
//   DEF_W_SEL      width of source/destination select fields
//   DEF_N_OUT      number of router output channels
//   DEF_PULSE_LEN  update strobe high time in clocks
//   prog_state_t   route programmer FSM states
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DEF_W_SEL     = 4;
    localparam int DEF_N_OUT     = 8;
    localparam int DEF_PULSE_LEN = 2;

    // ST_CHECK is only entered when the differential update build is enabled.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } prog_state_t;

endpackage

// File: rtl/route_programmer_if.sv
// -----------------------------------------------------------------------------
// route_programmer_if
//
// Purpose:
//   Bundles the controller-side request/status handshake and the router-side
//   single-entry update bus of the route programmer.
//
// Signals:
//   route_table_in     source select per destination, entry k at [k*W_SEL +: W_SEL]
//   output_active_in   channel activation mask
//   start_in           programming request (taken only while ready_out=1)
//   ready_out          programmer idle
//   busy_out           programmer sequencing
//   done_out           one-cycle completion pulse
//   src_select_out     to router src_select_in
//   dest_select_out    to router dest_select_in
//   output_active_out  to router output_active_in
//   update_out         to router update_in
//
// Modports:
//   master  controller / bench side (drives table, mask, start)
//   slave   route programmer side
// -----------------------------------------------------------------------------
interface route_programmer_if
    import router_pkg::*;
#(
    parameter int W_SEL = DEF_W_SEL,
    parameter int N_OUT = DEF_N_OUT
);

    logic [W_SEL*N_OUT-1:0] route_table_in;
    logic [N_OUT-1:0]       output_active_in;
    logic                   start_in;
    logic                   ready_out;
    logic                   busy_out;
    logic                   done_out;
    logic [W_SEL-1:0]       src_select_out;
    logic [W_SEL-1:0]       dest_select_out;
    logic [N_OUT-1:0]       output_active_out;
    logic                   update_out;

    modport master (
        output route_table_in,
        output output_active_in,
        output start_in,
        input  ready_out,
        input  busy_out,
        input  done_out,
        input  src_select_out,
        input  dest_select_out,
        input  output_active_out,
        input  update_out
    );

    modport slave (
        input  route_table_in,
        input  output_active_in,
        input  start_in,
        output ready_out,
        output busy_out,
        output done_out,
        output src_select_out,
        output dest_select_out,
        output output_active_out,
        output update_out
    );

endinterface

// File: rtl/strobe_timer.sv
// -----------------------------------------------------------------------------
// strobe_timer
//
// Purpose:
//   Load / count-down counter that times the PULSE_LEN-cycle high window of
//   the router update strobe. The count is non-zero exactly during the
//   window; expired_out flags the last cycle of the window so the FSM can
//   leave its strobe state on the following edge.
//
// Ports:
//   clk_in       system clock, posedge
//   rst_n_in     asynchronous active-low reset
//   load_in      load PULSE_LEN; window starts on the next cycle
//   expired_out  high in the final cycle of the window
// -----------------------------------------------------------------------------
module strobe_timer
    import router_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic load_in,
    output logic expired_out
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else if (load_in) begin
            count_q <= CW'(PULSE_LEN);
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_out = (count_q == CW'(1));

endmodule

// File: rtl/route_programmer.sv
// -----------------------------------------------------------------------------
// route_programmer
//
// Purpose:
//   Writes a complete routing table into the router's single-entry update
//   port. On an accepted start the table and activation mask are captured,
//   then destinations 0..N_OUT-1 are visited in order. Each entry gets one
//   SETUP cycle (selects driven, strobe low), PULSE_LEN STROBE cycles
//   (update_out high) and one HOLD cycle (strobe low, selects held), so the
//   router always sees stable selects around both strobe edges and at least
//   two low cycles between strobes. A DONE cycle pulses done_out before the
//   block returns to IDLE. Selects and mask keep their last values afterwards.
//
// Parameters:
//   W_SEL      select field width
//   N_OUT      number of router outputs (<= 2**W_SEL)
//   PULSE_LEN  update strobe high time in clocks (>= 1)
//
// Ports:
//   clk_in    system clock, posedge
//   rst_n_in  asynchronous active-low reset; aborts a sequence at once
//   bus       route_programmer_if.slave (controller handshake + router bus)
//
// Build option:
//   ROUTE_PROG_DIFF_EN  when defined, the last successfully written table
//                       and mask are kept in shadow registers. A CHECK cycle
//                       precedes each entry and entries equal to the shadow
//                       are skipped. Entry 0 is always written when the mask
//                       changed, so the new mask reaches the router.
// -----------------------------------------------------------------------------
module route_programmer
    import router_pkg::*;
#(
    parameter int W_SEL     = DEF_W_SEL,
    parameter int N_OUT     = DEF_N_OUT,
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    route_programmer_if.slave  bus
);

    prog_state_t            state_q;
    logic [W_SEL-1:0]       k_q;
    logic [W_SEL*N_OUT-1:0] tbl_q;
    logic [N_OUT-1:0]       mask_q;

    logic                   accept;
    logic                   last_entry;
    logic [W_SEL-1:0]       next_k;
    logic                   timer_load;
    logic                   timer_expired;

    function automatic logic [W_SEL-1:0] entry_of(
        input logic [W_SEL*N_OUT-1:0] tbl,
        input logic [W_SEL-1:0]       idx
    );
        return tbl[int'(idx)*W_SEL +: W_SEL];
    endfunction

    assign accept     = (state_q == ST_IDLE) && bus.start_in;
    assign last_entry = (k_q == W_SEL'(N_OUT - 1));
    assign next_k     = k_q + 1'b1;
    assign timer_load = (state_q == ST_SETUP);

    strobe_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_strobe_timer (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .load_in     (timer_load),
        .expired_out (timer_expired)
    );

    // Request snapshot: later input changes are ignored until the next start.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            tbl_q  <= bus.route_table_in;
            mask_q <= bus.output_active_in;
        end
    end

`ifdef ROUTE_PROG_DIFF_EN
    logic [W_SEL*N_OUT-1:0] shadow_tbl_q;
    logic [N_OUT-1:0]       shadow_mask_q;
    logic                   shadow_valid_q;
    logic                   skip_entry;

    // The mask only travels with a strobe, so a mask change forces entry 0.
    assign skip_entry = shadow_valid_q
                     && (entry_of(tbl_q, k_q) == entry_of(shadow_tbl_q, k_q))
                     && !((k_q == '0) && (mask_q != shadow_mask_q));

    // Shadow reflects what the router holds after a completed sequence.
    always_ff @(posedge clk_in) begin
        if (state_q == ST_DONE) begin
            shadow_tbl_q  <= tbl_q;
            shadow_mask_q <= mask_q;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q               <= ST_IDLE;
            k_q                   <= '0;
            bus.ready_out         <= 1'b1;
            bus.busy_out          <= 1'b0;
            bus.done_out          <= 1'b0;
            bus.update_out        <= 1'b0;
            bus.src_select_out    <= '0;
            bus.dest_select_out   <= '0;
            bus.output_active_out <= '0;
`ifdef ROUTE_PROG_DIFF_EN
            shadow_valid_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        k_q           <= '0;
                        bus.ready_out <= 1'b0;
                        bus.busy_out  <= 1'b1;
`ifdef ROUTE_PROG_DIFF_EN
                        state_q       <= ST_CHECK;
`else
                        // Snapshot lands on this same edge, so entry 0 is
                        // taken straight from the inputs.
                        state_q               <= ST_SETUP;
                        bus.src_select_out    <= entry_of(bus.route_table_in, '0);
                        bus.dest_select_out   <= '0;
                        bus.output_active_out <= bus.output_active_in;
`endif
                    end
                end

`ifdef ROUTE_PROG_DIFF_EN
                ST_CHECK: begin
                    if (skip_entry) begin
                        if (last_entry) begin
                            state_q      <= ST_DONE;
                            bus.done_out <= 1'b1;
                        end else begin
                            k_q <= next_k;
                        end
                    end else begin
                        state_q               <= ST_SETUP;
                        bus.src_select_out    <= entry_of(tbl_q, k_q);
                        bus.dest_select_out   <= k_q;
                        bus.output_active_out <= mask_q;
                    end
                end
`endif

                ST_SETUP: begin
                    state_q        <= ST_STROBE;
                    bus.update_out <= 1'b1;
                end

                ST_STROBE: begin
                    if (timer_expired) begin
                        state_q        <= ST_HOLD;
                        bus.update_out <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (last_entry) begin
                        state_q      <= ST_DONE;
                        bus.done_out <= 1'b1;
                    end else begin
                        k_q <= next_k;
`ifdef ROUTE_PROG_DIFF_EN
                        state_q <= ST_CHECK;
`else
                        state_q               <= ST_SETUP;
                        bus.src_select_out    <= entry_of(tbl_q, next_k);
                        bus.dest_select_out   <= next_k;
                        bus.output_active_out <= mask_q;
`endif
                    end
                end

                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    bus.done_out  <= 1'b0;
                    bus.busy_out  <= 1'b0;
                    bus.ready_out <= 1'b1;
`ifdef ROUTE_PROG_DIFF_EN
                    shadow_valid_q <= 1'b1;
`endif
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_programmer.sv
// -----------------------------------------------------------------------------
// tb_route_programmer
//
// Directed bench for route_programmer. A main instance uses the default
// geometry (W_SEL=4, N_OUT=8, PULSE_LEN=2); a second instance uses N_OUT=1,
// PULSE_LEN=1. A router model latches select/mask on every rising edge of
// update_out and records per-strobe data, high length, select stability and
// the low gap between strobes. Expected timings follow from
// done cycle = N_OUT * entry_length + 1, with cycle 1 the first cycle after
// the accepting edge. Honors ROUTE_PROG_DIFF_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_route_programmer;

`ifdef ROUTE_PROG_DIFF_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int ENTRY   = 2 + 2 + EXTRA;
    localparam int ENTRY_S = 1 + 2 + EXTRA;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    route_programmer_if #(.W_SEL(4), .N_OUT(8)) bus ();
    route_programmer_if #(.W_SEL(4), .N_OUT(1)) bus_s ();

    route_programmer #(.W_SEL(4), .N_OUT(8), .PULSE_LEN(2)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    route_programmer #(.W_SEL(4), .N_OUT(1), .PULSE_LEN(1)) dut_s (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- router model / strobe monitor ----------------
    logic [3:0] st_dest [64];
    logic [3:0] st_src  [64];
    logic [7:0] st_mask [64];
    int         st_len  [64];
    int         nstrobe, unstable, min_gap, high_run, low_run;
    bit         seen;
    logic       upd_q;
    logic [3:0] prev_src, prev_dest;
    logic [7:0] prev_mask;
    logic [3:0] router_tbl [8];
    logic [7:0] router_mask;

    always @(posedge clk) begin
        if (bus.update_out === 1'b1 && upd_q !== 1'b1) begin
            if (bus.src_select_out !== prev_src || bus.dest_select_out !== prev_dest ||
                bus.output_active_out !== prev_mask)
                unstable++;
            if (seen && low_run < min_gap) min_gap = low_run;
            if (nstrobe < 64) begin
                st_dest[nstrobe] = bus.dest_select_out;
                st_src[nstrobe]  = bus.src_select_out;
                st_mask[nstrobe] = bus.output_active_out;
                st_len[nstrobe]  = 0;
            end
            router_tbl[bus.dest_select_out[2:0]] = bus.src_select_out;
            router_mask = bus.output_active_out;
            nstrobe++;
            high_run = 0;
            seen = 1'b1;
        end
        if (bus.update_out !== 1'b1 && upd_q === 1'b1) begin
            if (bus.src_select_out !== prev_src || bus.dest_select_out !== prev_dest ||
                bus.output_active_out !== prev_mask)
                unstable++;
            if (nstrobe > 0 && nstrobe <= 64) st_len[nstrobe-1] = high_run;
            low_run = 0;
        end
        if (bus.update_out === 1'b1) high_run++;
        else                         low_run++;
        prev_src  = bus.src_select_out;
        prev_dest = bus.dest_select_out;
        prev_mask = bus.output_active_out;
        upd_q     = bus.update_out;
    end

    task automatic clear_mon();
        nstrobe  = 0;
        unstable = 0;
        min_gap  = 99;
        high_run = 0;
        low_run  = 0;
        seen     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start and return the cycle in which done_out is seen (-1 on timeout).
    // Inputs are scrambled after acceptance to show that the snapshot is used.
    task automatic start_and_wait(input logic [31:0] tbl, input logic [7:0] mask,
                                  output int done_cyc);
        bus.route_table_in   = tbl;
        bus.output_active_in = mask;
        bus.start_in         = 1'b1;
        tick();
        bus.start_in         = 1'b0;
        bus.route_table_in   = ~tbl;
        bus.output_active_in = ~mask;
        done_cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            if (bus.done_out === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.route_table_in     = '0;
        bus.output_active_in   = '0;
        bus.start_in           = 1'b0;
        bus_s.route_table_in   = '0;
        bus_s.output_active_in = '0;
        bus_s.start_in         = 1'b0;
        upd_q = 1'b0;
        clear_mon();
        for (int i = 0; i < 8; i++) router_tbl[i] = 4'h0;
        tick();
        tick();
        checks++;
        if (bus.ready_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: ready/busy/done=%b%b%b required 100",
                     bus.ready_out, bus.busy_out, bus.done_out);
        end
        checks++;
        if (bus.update_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_update: got %b required 0", bus.update_out);
        end
        checks++;
        if (bus.src_select_out !== 4'h0 || bus.dest_select_out !== 4'h0 ||
            bus.output_active_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_selects: src=%h dest=%h mask=%h required 0 0 00",
                     bus.src_select_out, bus.dest_select_out, bus.output_active_out);
        end
        checks++;
        if (bus_s.ready_out !== 1'b1 || bus_s.update_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: ready=%b update=%b required 1 0",
                     bus_s.ready_out, bus_s.update_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_table();
        logic [31:0] tbl;
        int dc;
        tbl = 32'h01234567;
        clear_mon();
        start_and_wait(tbl, 8'hA5, dc);
        checks++;
        if (dc !== 8*ENTRY + 1) begin
            errors++;
            $display("FAIL full_done_cycle: got %0d required %0d", dc, 8*ENTRY + 1);
        end
        checks++;
        if (bus.busy_out !== 1'b1 || bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_in_done: busy=%b ready=%b required 1 0",
                     bus.busy_out, bus.ready_out);
        end
        tick();
        checks++;
        if (bus.ready_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_after: ready/busy/done=%b%b%b required 100",
                     bus.ready_out, bus.busy_out, bus.done_out);
        end
        checks++;
        if (bus.src_select_out !== 4'h0 || bus.dest_select_out !== 4'h7 ||
            bus.output_active_out !== 8'hA5) begin
            errors++;
            $display("FAIL full_outputs_held: src=%h dest=%h mask=%h required 0 7 a5",
                     bus.src_select_out, bus.dest_select_out, bus.output_active_out);
        end
        checks++;
        if (nstrobe !== 8) begin
            errors++;
            $display("FAIL full_strobe_count: got %0d required 8", nstrobe);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (st_dest[i] !== 4'(i) || st_src[i] !== tbl[i*4 +: 4] ||
                st_mask[i] !== 8'hA5 || st_len[i] !== 2) begin
                errors++;
                $display("FAIL full_strobe_%0d: dest=%h src=%h mask=%h len=%0d required %h %h a5 2",
                         i, st_dest[i], st_src[i], st_mask[i], st_len[i], 4'(i), tbl[i*4 +: 4]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (router_tbl[i] !== tbl[i*4 +: 4]) begin
                errors++;
                $display("FAIL full_router_entry_%0d: got %h required %h",
                         i, router_tbl[i], tbl[i*4 +: 4]);
            end
        end
        checks++;
        if (unstable !== 0 || min_gap < 2) begin
            errors++;
            $display("FAIL full_envelope: unstable=%0d min_gap=%0d required 0 and >=2",
                     unstable, min_gap);
        end
    endtask

    task automatic test_busy_restart();
        int dc;
        int bad_ready;
        clear_mon();
        bad_ready = 0;
        dc = -1;
        bus.route_table_in   = 32'h76543210;
        bus.output_active_in = 8'h3C;
        bus.start_in         = 1'b1;
        tick();
        bus.start_in = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            bus.start_in = (c == 5 || c == 20);
            if (bus.ready_out !== 1'b0) bad_ready++;
            if (bus.done_out === 1'b1) begin
                dc = c;
                break;
            end
            tick();
        end
        bus.start_in = 1'b0;
        checks++;
        if (bad_ready !== 0) begin
            errors++;
            $display("FAIL restart_ready_low: %0d cycles with ready high, required 0", bad_ready);
        end
        checks++;
        if (dc !== 8*ENTRY + 1) begin
            errors++;
            $display("FAIL restart_done_cycle: got %0d required %0d", dc, 8*ENTRY + 1);
        end
        checks++;
        if (nstrobe !== 8) begin
            errors++;
            $display("FAIL restart_strobe_count: got %0d required 8", nstrobe);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.busy_out !== 1'b0 || bus.ready_out !== 1'b1 || nstrobe !== 8) begin
            errors++;
            $display("FAIL restart_not_queued: busy=%b ready=%b strobes=%0d required 0 1 8",
                     bus.busy_out, bus.ready_out, nstrobe);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] tbl;
        int dc;
        bit found;
        tbl = 32'h89ABCDEF;
        found = 1'b0;
        bus.route_table_in   = tbl;
        bus.output_active_in = 8'h0F;
        bus.start_in         = 1'b1;
        tick();
        bus.start_in = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (bus.update_out === 1'b1 && bus.dest_select_out === 4'h3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_entry3: strobe at dest 3 not seen, required seen");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.update_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_update_async: got %b required 0", bus.update_out);
        end
        checks++;
        if (bus.ready_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0 ||
            bus.src_select_out !== 4'h0 || bus.dest_select_out !== 4'h0 ||
            bus.output_active_out !== 8'h00) begin
            errors++;
            $display("FAIL abort_outputs: rdy=%b busy=%b done=%b src=%h dest=%h mask=%h required 1 0 0 0 0 00",
                     bus.ready_out, bus.busy_out, bus.done_out, bus.src_select_out,
                     bus.dest_select_out, bus.output_active_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        clear_mon();
        start_and_wait(tbl, 8'h0F, dc);
        checks++;
        if (dc !== 8*ENTRY + 1 || nstrobe !== 8) begin
            errors++;
            $display("FAIL abort_reprogram: done=%0d strobes=%0d required %0d 8",
                     dc, nstrobe, 8*ENTRY + 1);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (router_tbl[i] !== tbl[i*4 +: 4]) begin
                errors++;
                $display("FAIL abort_router_entry_%0d: got %h required %h",
                         i, router_tbl[i], tbl[i*4 +: 4]);
            end
        end
        tick();
    endtask

    // Repeated programming: differential build skips unchanged entries,
    // the default build rewrites everything.
    task automatic test_diff();
        int dc;
        // Full write of a table that differs everywhere from the router contents.
        clear_mon();
        start_and_wait(32'h01234567, 8'hA5, dc);
        checks++;
        if (dc !== 8*ENTRY + 1 || nstrobe !== 8) begin
            errors++;
            $display("FAIL diff_first: done=%0d strobes=%0d required %0d 8", dc, nstrobe, 8*ENTRY + 1);
        end
        tick();
        // Entry 5 changes 2 -> 9.
        clear_mon();
        start_and_wait(32'h01934567, 8'hA5, dc);
`ifdef ROUTE_PROG_DIFF_EN
        checks++;
        if (dc !== 13 || nstrobe !== 1 || st_dest[0] !== 4'h5 || st_src[0] !== 4'h9 ||
            st_mask[0] !== 8'hA5) begin
            errors++;
            $display("FAIL diff_entry5: done=%0d strobes=%0d dest=%h src=%h mask=%h required 13 1 5 9 a5",
                     dc, nstrobe, st_dest[0], st_src[0], st_mask[0]);
        end
`else
        checks++;
        if (dc !== 33 || nstrobe !== 8 || st_dest[5] !== 4'h5 || st_src[5] !== 4'h9) begin
            errors++;
            $display("FAIL rewrite_entry5: done=%0d strobes=%0d dest=%h src=%h required 33 8 5 9",
                     dc, nstrobe, st_dest[5], st_src[5]);
        end
`endif
        tick();
        // Same table, mask A5 -> FF.
        clear_mon();
        start_and_wait(32'h01934567, 8'hFF, dc);
`ifdef ROUTE_PROG_DIFF_EN
        checks++;
        if (dc !== 13 || nstrobe !== 1 || st_dest[0] !== 4'h0 || st_src[0] !== 4'h7 ||
            st_mask[0] !== 8'hFF) begin
            errors++;
            $display("FAIL diff_mask: done=%0d strobes=%0d dest=%h src=%h mask=%h required 13 1 0 7 ff",
                     dc, nstrobe, st_dest[0], st_src[0], st_mask[0]);
        end
`else
        checks++;
        if (dc !== 33 || nstrobe !== 8 || st_mask[0] !== 8'hFF || st_mask[7] !== 8'hFF) begin
            errors++;
            $display("FAIL rewrite_mask: done=%0d strobes=%0d mask0=%h mask7=%h required 33 8 ff ff",
                     dc, nstrobe, st_mask[0], st_mask[7]);
        end
`endif
        tick();
        // Nothing changed.
        clear_mon();
        start_and_wait(32'h01934567, 8'hFF, dc);
`ifdef ROUTE_PROG_DIFF_EN
        checks++;
        if (dc !== 9 || nstrobe !== 0) begin
            errors++;
            $display("FAIL diff_no_change: done=%0d strobes=%0d required 9 0", dc, nstrobe);
        end
`else
        checks++;
        if (dc !== 33 || nstrobe !== 8) begin
            errors++;
            $display("FAIL rewrite_same: done=%0d strobes=%0d required 33 8", dc, nstrobe);
        end
`endif
        tick();
    endtask

    task automatic test_small();
        int dc;
        int highs;
        int first_high;
        logic [3:0] hs_src, hs_dest;
        logic hs_mask;
        dc = -1;
        highs = 0;
        first_high = -1;
        hs_src = 4'h0;
        hs_dest = 4'hF;
        hs_mask = 1'b0;
        bus_s.route_table_in   = 4'hB;
        bus_s.output_active_in = 1'b1;
        bus_s.start_in         = 1'b1;
        tick();
        bus_s.start_in = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus_s.update_out === 1'b1) begin
                highs++;
                if (first_high < 0) first_high = c;
                hs_src  = bus_s.src_select_out;
                hs_dest = bus_s.dest_select_out;
                hs_mask = bus_s.output_active_out[0];
            end
            if (bus_s.done_out === 1'b1) begin
                dc = c;
                break;
            end
            tick();
        end
        checks++;
        if (dc !== ENTRY_S + 1) begin
            errors++;
            $display("FAIL small_done_cycle: got %0d required %0d", dc, ENTRY_S + 1);
        end
        checks++;
        if (highs !== 1 || first_high !== 2 + EXTRA) begin
            errors++;
            $display("FAIL small_strobe: high cycles=%0d first=%0d required 1 %0d",
                     highs, first_high, 2 + EXTRA);
        end
        checks++;
        if (hs_src !== 4'hB || hs_dest !== 4'h0 || hs_mask !== 1'b1) begin
            errors++;
            $display("FAIL small_selects: src=%h dest=%h mask=%b required b 0 1",
                     hs_src, hs_dest, hs_mask);
        end
        tick();
        checks++;
        if (bus_s.ready_out !== 1'b1 || bus_s.busy_out !== 1'b0) begin
            errors++;
            $display("FAIL small_ready_after: ready=%b busy=%b required 1 0",
                     bus_s.ready_out, bus_s.busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_full_table();
        test_busy_restart();
        test_reset_abort();
        test_diff();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/route_programmer.md
# route_programmer

Sequences a full routing table from the frontpanel controller into the router's single-entry update port. The router latches one destination's source select (plus the activation mask) on each rising edge of its update strobe. This block therefore walks destinations 0..N_OUT-1 and drives select, destination and mask with a clean setup / strobe / hold envelope per entry. It sits between the frontpanel controller and the router, and reports busy/done back to the controller.

## Interface
- W_SEL, 4, width of source/destination select fields
- N_OUT, 8, number of router output channels (≤ 2^W_SEL)
- PULSE_LEN, 2, update strobe high time in clocks (≥ 1)
- clk_in  input  1  system clock; all logic on posedge
- rst_n_in  input  1  asynchronous, active-low reset
- route_table_in  input  W_SEL*N_OUT  source select for destination k at bits [k*W_SEL +: W_SEL]
- output_active_in  input  N_OUT  channel activation mask
- start_in  input  1  request programming; accepted only when ready_out=1
- ready_out  output  1  high in IDLE
- busy_out  output  1  high in every non-IDLE state
- done_out  output  1  one-cycle pulse on completion
- src_select_out  output  W_SEL  to router src_select_in
- dest_select_out  output  W_SEL  to router dest_select_in
- output_active_out  output  N_OUT  to router output_active_in
- update_out  output  1  to router update_in

## Operation
- All outputs are registered. Reset values:
  - ready_out = 1.
  - busy_out, done_out, update_out, src_select_out, dest_select_out and output_active_out = 0.
- States: IDLE, SETUP, STROBE, HOLD, DONE (plus CHECK, see Configuration).
- IDLE:
  - On start_in=1, snapshot route_table_in and output_active_in into internal registers.
  - Set k=0 and go to SETUP.
  - Input changes after acceptance are ignored until the next start.
- SETUP (1 cycle): drive src_select_out=tbl[k], dest_select_out=k, output_active_out=mask, update_out=0.
- STROBE (PULSE_LEN cycles): update_out=1; selects held.
- HOLD (1 cycle): update_out=0; selects held. If k=N_OUT-1 go to DONE, else k++ and go to SETUP.
- DONE (1 cycle): done_out=1; latch snapshot into shadow registers; set shadow_valid; go to IDLE.
- After DONE, select and mask outputs keep their last values. update_out stays 0 outside STROBE.
- start_in while busy is ignored and is not queued.
- Reset mid-sequence:
  - Aborts immediately: update_out drops to 0 asynchronously.
  - shadow_valid clears.
  - The router itself has no reset, so the next start reprograms every entry.
- k is W_SEL wide; the counter never wraps past N_OUT-1.

## Timing
- Start accepted on edge 0. SETUP for k=0 is visible after edge 0.
- Each entry takes PULSE_LEN+2 cycles.
- done_out is high in the cycle after the last HOLD, i.e. cycle N_OUT*(PULSE_LEN+2)+1. ready_out returns one cycle later.
- Defaults: done_out at cycle 33; ready_out at 34.
- Guarantees toward the router:
  - Selects are stable ≥1 clock before every update_out rising edge and ≥1 clock after every falling edge.
  - Consecutive strobes are separated by ≥2 low cycles.

## Configuration
- Macro ROUTE_PROG_DIFF_EN.
- Defined:
  - A CHECK state precedes each SETUP and takes 1 cycle per destination.
  - If shadow_valid=1 and tbl[k]==shadow[k], skip that entry: go to next k, or to DONE after k=N_OUT-1.
  - If the mask differs from the shadow mask, entry 0 is always programmed so the new mask reaches the router.
  - If nothing changed, the sequence is N_OUT CHECK cycles followed by DONE with no strobe.
- Undefined:
  - No CHECK state and no shadow compare. Every entry is programmed.
  - Shadow registers and shadow_valid are not synthesized.

## Structure
- Shared package router_pkg holds:
  - the state encoding constants;
  - the default W_SEL / N_OUT values shared with the router;
  - the PULSE_LEN default.
- One sub-module, strobe_timer: a load/count-down counter that generates the PULSE_LEN-cycle high window and an expiry flag for the FSM.

## Test plan
- Defaults, table {7,6,5,4,3,2,1,0}, mask 8'hA5, start:
  - 8 strobes, each 2 cycles high, with dest 0..7 / src 7..0.
  - Mask 8'hA5 on every strobe.
  - done_out at cycle 33.
  - A router model captures the table exactly.
- Assert start_in again at cycles 5 and 20 of a sequence → ignored; exactly 8 strobes; ready_out=0 throughout.
- Deassert rst_n_in while update_out=1 at entry 3:
  - update_out=0 and all outputs return to reset values immediately.
  - The next start programs all 8 entries.
- ROUTE_PROG_DIFF_EN, program the table twice with only entry 5 changed (2→9): second run issues one strobe (dest 5, src 9); done at cycle 8+4+1.
- ROUTE_PROG_DIFF_EN, same table, mask changed 8'hA5→8'hFF → single strobe at dest 0 carrying mask 8'hFF.
- PULSE_LEN=1, N_OUT=1 → SETUP, 1-cycle strobe, HOLD, done at cycle 4.
